// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard and forwarding controller built on a shift-register
// scoreboard of in-flight register writes, with a control-transfer shadow.
module id_hazard_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 3,
  parameter int LOAD_LAT  = 1,
  parameter int BR_SHADOW = 3,
  parameter int SELW      = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wreg,
  input  logic [REG_AW-1:0] id_rn,
  input  logic              id_m2reg,
  input  logic              id_is_ctrl,
  input  logic              pipe_hold,
  output logic              stall_en,
  output logic              id_fire,
  output logic [SELW-1:0]   alu_a_select,
  output logic [SELW-1:0]   alu_b_select
);

  localparam int SHW = (BR_SHADOW > 0) ? $clog2(BR_SHADOW+1) : 1;

  typedef struct packed {
    logic              v;
    logic              wreg;
    logic [REG_AW-1:0] rn;
    logic              m2reg;
  } ent_t;

  ent_t            ent [1:DEPTH];
  logic [SHW-1:0]  shadow_cnt;

  logic [SELW-1:0] a_k;
  logic [SELW-1:0] b_k;
  logic            a_ld_haz;
  logic            b_ld_haz;
  logic            hazard;
  logic            stall_raw;
  logic            fire_raw;

  function automatic logic hit(ent_t e, logic [REG_AW-1:0] s);
    return e.v && e.wreg && (e.rn == s) && (s != '0);
  endfunction

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    a_k      = '0;
    b_k      = '0;
    a_ld_haz = 1'b0;
    b_ld_haz = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit(ent[k], id_rs)) begin
        a_k      = SELW'(k);
        a_ld_haz = ent[k].m2reg && (k <= LOAD_LAT);
      end
      if (hit(ent[k], id_rt)) begin
        b_k      = SELW'(k);
        b_ld_haz = ent[k].m2reg && (k <= LOAD_LAT);
      end
    end
  end

  always_comb begin
    hazard    = (id_use_rs && a_ld_haz) ||
                (id_use_rt && b_ld_haz);
    stall_raw = id_valid &&
                (hazard || (shadow_cnt != '0) ||
                 pipe_hold);
    fire_raw  = id_valid && !stall_raw;
  end

  always_comb begin
    stall_en     = 1'b0;
    id_fire      = 1'b0;
    alu_a_select = '0;
    alu_b_select = '0;
    if (!rst) begin
      stall_en     = stall_raw;
      id_fire      = fire_raw;
      alu_a_select = id_use_rs ? a_k : '0;
      alu_b_select = id_use_rt ? b_k : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++)
        ent[k] <= '0;
      shadow_cnt <= '0;
    end else if (!pipe_hold) begin
      for (int k = DEPTH; k >= 2; k--)
        ent[k] <= ent[k-1];
      ent[1] <= '{v: fire_raw, wreg: id_wreg,
                  rn: id_rn, m2reg: id_m2reg};
      if (fire_raw && id_is_ctrl)
        shadow_cnt <= SHW'(BR_SHADOW);
      else if (shadow_cnt != '0)
        shadow_cnt <= shadow_cnt - SHW'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: directed scenarios followed by random
// traffic, all checked against an age-based model of in-flight writes.
module tb_id_hazard_scoreboard;
  localparam int AW = 5;
  localparam int D  = 3;
  localparam int LL = 1;
  localparam int BS = 3;
  localparam int SW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_wreg;
  logic [AW-1:0] id_rn;
  logic          id_m2reg;
  logic          id_is_ctrl;
  logic          pipe_hold;
  logic          stall_en;
  logic          id_fire;
  logic [SW-1:0] alu_a_select;
  logic [SW-1:0] alu_b_select;

  always #5 clk = ~clk;

  id_hazard_scoreboard #(
    .REG_AW(AW), .DEPTH(D), .LOAD_LAT(LL), .BR_SHADOW(BS)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_rn(id_rn),
    .id_m2reg(id_m2reg), .id_is_ctrl(id_is_ctrl),
    .pipe_hold(pipe_hold), .stall_en(stall_en),
    .id_fire(id_fire), .alu_a_select(alu_a_select),
    .alu_b_select(alu_b_select)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Model: every issued write carries its age in stages past ID.
  typedef struct {
    int age;
    bit wreg;
    int rn;
    bit ld;
  } w_t;

  w_t q[$];
  int sh = 0;

  function automatic void young(input int s, output int k,
                                output bit ld);
    k  = 0;
    ld = 0;
    foreach (q[i])
      if (s != 0 && q[i].wreg && q[i].rn == s &&
          (k == 0 || q[i].age < k)) begin
        k  = q[i].age;
        ld = q[i].ld;
      end
  endfunction

  function automatic void mdl(output int sa, output int sb,
                              output int st, output int fi);
    int ka, kb;
    bit la, lb, haz;
    sa = 0; sb = 0; st = 0; fi = 0;
    if (rst) return;
    young(int'(id_rs), ka, la);
    young(int'(id_rt), kb, lb);
    sa  = id_use_rs ? ka : 0;
    sb  = id_use_rt ? kb : 0;
    haz = (id_use_rs && la && ka != 0 && ka <= LL) ||
          (id_use_rt && lb && kb != 0 && kb <= LL);
    st  = (id_valid && (haz || sh != 0 || pipe_hold)) ? 1 : 0;
    fi  = (id_valid && st == 0) ? 1 : 0;
  endfunction

  task automatic cyc();
    int sa, sb, st, fi;
    #1;
    mdl(sa, sb, st, fi);
    chk("m_stall", 32'(stall_en), sa*0 + st);
    chk("m_fire", 32'(id_fire), fi);
    chk("m_sel_a", 32'(alu_a_select), sa);
    chk("m_sel_b", 32'(alu_b_select), sb);
    @(posedge clk);
    if (rst) begin
      q.delete();
      sh = 0;
    end else if (!pipe_hold) begin
      foreach (q[i]) q[i].age++;
      for (int i = q.size()-1; i >= 0; i--)
        if (q[i].age > D) q.delete(i);
      if (fi != 0)
        q.push_back('{age: 1, wreg: id_wreg,
                      rn: int'(id_rn), ld: id_m2reg});
      if (fi != 0 && id_is_ctrl) sh = BS;
      else if (sh > 0) sh--;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rt = '0;
    id_use_rs = 0; id_use_rt = 0; id_wreg = 0;
    id_rn = '0; id_m2reg = 0; id_is_ctrl = 0;
    pipe_hold = 0;
  endtask

  initial begin
    int exp_a[4];
    exp_a = '{1, 2, 3, 0};
    idle();
    rst = 1;
    @(negedge clk);
    // Outputs must be forced low during reset.
    id_valid = 1; pipe_hold = 1; id_rs = 5; id_use_rs = 1;
    cyc();
    #1 chk("rst_stall", 32'(stall_en), 0);
    cyc();

    // 1. reset release
    rst = 0; pipe_hold = 0;
    #1;
    chk("t1_stall", 32'(stall_en), 0);
    chk("t1_fire", 32'(id_fire), 1);
    chk("t1_sel_a", 32'(alu_a_select), 0);
    cyc();

    // 2. ALU forward chain
    idle();
    id_valid = 1; id_wreg = 1; id_rn = 5;
    cyc();
    idle();
    id_rs = 5; id_use_rs = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_sel_a", 32'(alu_a_select), exp_a[i]);
      cyc();
    end

    // 3. load-use
    idle();
    id_valid = 1; id_wreg = 1; id_rn = 7; id_m2reg = 1;
    cyc();
    idle();
    id_valid = 1; id_rt = 7; id_use_rt = 1;
    #1;
    chk("t3_stall1", 32'(stall_en), 1);
    chk("t3_fire1", 32'(id_fire), 0);
    cyc();
    #1;
    chk("t3_stall2", 32'(stall_en), 0);
    chk("t3_sel_b", 32'(alu_b_select), 2);
    chk("t3_fire2", 32'(id_fire), 1);
    cyc();

    // 4. youngest wins, reg 0 never matches
    idle();
    id_valid = 1; id_wreg = 1; id_rn = 4;
    cyc();
    cyc();
    idle();
    id_valid = 1; id_rs = 4; id_use_rs = 1;
    #1 chk("t4_young", 32'(alu_a_select), 1);
    cyc();
    idle();
    id_valid = 1; id_wreg = 1; id_rn = 0;
    cyc();
    idle();
    id_valid = 1; id_rs = 0; id_use_rs = 1;
    #1 chk("t4_reg0", 32'(alu_a_select), 0);
    cyc();

    // 5. control shadow, then shadow stretched by a hold
    idle();
    repeat (3) cyc();
    id_valid = 1; id_is_ctrl = 1;
    #1 chk("t5_ctrl_fire", 32'(id_fire), 1);
    cyc();
    id_is_ctrl = 0;
    for (int i = 1; i <= 3; i++) begin
      #1 chk("t5_shadow", 32'(stall_en), 1);
      cyc();
    end
    #1 chk("t5_refire", 32'(id_fire), 1);
    cyc();
    idle();
    repeat (3) cyc();
    id_valid = 1; id_is_ctrl = 1;
    cyc();
    id_is_ctrl = 0;
    cyc();
    pipe_hold = 1;
    #1 chk("t5_hold_stall", 32'(stall_en), 1);
    cyc();
    pipe_hold = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t5_hold_shadow", 32'(stall_en), 1);
      cyc();
    end
    #1 chk("t5_hold_fire", 32'(id_fire), 1);
    cyc();

    // 6. reset mid-flight drops in-flight writes
    idle();
    id_valid = 1; id_wreg = 1; id_rn = 9;
    cyc();
    idle();
    rst = 1;
    cyc();
    rst = 0;
    id_valid = 1; id_rs = 9; id_use_rs = 1;
    #1;
    chk("t6_sel_a", 32'(alu_a_select), 0);
    chk("t6_stall", 32'(stall_en), 0);
    cyc();

    // Random traffic over a small register set.
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 99) < 2);
      id_valid   = ($urandom_range(0, 99) < 80);
      id_rs      = AW'($urandom_range(0, 5));
      id_rt      = AW'($urandom_range(0, 5));
      id_use_rs  = $urandom_range(0, 1) == 1;
      id_use_rt  = $urandom_range(0, 1) == 1;
      id_wreg    = ($urandom_range(0, 99) < 70);
      id_rn      = AW'($urandom_range(0, 5));
      id_m2reg   = ($urandom_range(0, 99) < 35);
      id_is_ctrl = ($urandom_range(0, 99) < 8);
      pipe_hold  = ($urandom_range(0, 99) < 10);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
Parametrised hazard and forwarding controller for the decode stage. It replaces fixed EXE/MEM/WB comparisons with a DEPTH-entry shift-register scoreboard of in-flight register writes. Each cycle it decides whether the ID instruction may issue (stall_en, id_fire) and drives per-operand forwarding selects. It also enforces a configurable control-transfer shadow after jumps and branches.

Parameters:
REG_AW, 5, register-number width
DEPTH, 3, number of tracked post-ID stages; entry 1 = EXE, entry DEPTH = WB
LOAD_LAT, 1, a load's data can be forwarded only from entries with index > LOAD_LAT
BR_SHADOW, 3, bubble cycles inserted after a control instruction issues
SELW, $clog2(DEPTH+1), forwarding-select width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a valid instruction
id_rs  in  REG_AW  source A register number
id_rt  in  REG_AW  source B register number
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_wreg  in  1  instruction writes a register
id_rn  in  REG_AW  destination register number
id_m2reg  in  1  instruction is a load
id_is_ctrl  in  1  instruction is a jump, beq or bne
pipe_hold  in  1  downstream freeze; scoreboard holds
stall_en  out  1  ID must hold and insert a bubble
id_fire  out  1  ID instruction issues this cycle
alu_a_select  out  SELW  0 = regfile, k = forward from entry k
alu_b_select  out  SELW  same encoding, for rt

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- State:
  - entry[1..DEPTH], each holding {v, wreg, rn, m2reg};
  - shadow_cnt, with width sufficient for BR_SHADOW.
- Reset: at the next edge with rst=1, all entries v=0 and shadow_cnt=0. While rst=1, outputs are forced to stall_en=0, id_fire=0, selects=0.
- Match rule: entry k matches source s when entry[k].v, entry[k].wreg, entry[k].rn==s, and s!=0. Register 0 never matches.
- Youngest match wins (lowest k).
- Forwarding select for an operand:
  - k of the youngest match, if the use bit is set;
  - otherwise 0.
  - Selects are combinational from the current inputs and registered state, valid in the same cycle.
- Load-use hazard: the youngest match for a used operand has m2reg=1 and k <= LOAD_LAT.
- stall_en = id_valid & (hazard | shadow_cnt!=0 | pipe_hold).
- id_fire = id_valid & ~stall_en.
- Update when pipe_hold=0:
  - entries shift, so entry[k+1] <= entry[k] and entry[DEPTH] is discarded;
  - entry[1] <= {id_fire, id_wreg, id_rn, id_m2reg}; a non-fire inserts a bubble with v=0;
  - shadow_cnt: loads BR_SHADOW if id_fire & id_is_ctrl; else decrements if nonzero; else stays 0.
- Update when pipe_hold=1: entries and shadow_cnt hold.
- Control instruction blocked by a hazard: stalls normally. The shadow starts only on the cycle it fires.
- Simultaneous hazard and shadow: stall persists until both clear.
- Reset mid-operation: all in-flight entries are dropped and no forwarding survives.
- BR_SHADOW=0: the shadow is disabled.
- LOAD_LAT=0: loads forward from entry 1 with no stall.

Test Plan:
All scenarios use DEPTH=3, LOAD_LAT=1, BR_SHADOW=3.
1. Reset: hold rst=1 for 2 cycles, then id_valid=1, rs=5, use_rs=1 → stall_en=0, id_fire=1, alu_a_select=0.
2. ALU forward chain: fire wreg=1, rn=5 (non-load) at cycle T. Then present rs=5, use_rs=1 with id_valid=0 each cycle → alu_a_select is 1, 2, 3, 0 at cycles T+1 through T+4.
3. Load-use: fire m2reg=1, rn=7 at T. At T+1, rt=7, use_rt=1 → stall_en=1, id_fire=0. At T+2 → stall_en=0, alu_b_select=2, id_fire=1.
4. Youngest wins and reg 0: fire rn=4 at T and T+1. At T+2, rs=4 → alu_a_select=1 (not 2). Separately, fire rn=0 with wreg=1, then rs=0 → select 0.
5. Control shadow: fire id_is_ctrl=1 at T, keep id_valid=1 → stall_en=1 at T+1..T+3, id_fire=1 at T+4. Pulse pipe_hold=1 at T+2 → firing is delayed to T+5.
6. Reset mid-flight: fire rn=9, assert rst one cycle, release; rs=9 → alu_a_select=0, stall_en=0.
